// File: rtl/aftab_daru_pkg.sv
// Shared types and constants for the AFTAB data/address read unit.
package aftab_daru_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } daru_state_e;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd3;

  localparam int LANE_W = 2;

endpackage

// File: rtl/aftab_daru_misalign_chk.sv
// Combinational misalignment flags for instruction fetches and data loads.
module aftab_daru_misalign_chk
  import aftab_daru_pkg::*;
(
  input  logic [1:0] addr_low,
  input  logic [1:0] n_bytes,
  input  logic       data_instr_bar,
  input  logic       check_en,
  output logic       instr_misaligned,
  output logic       load_misaligned
);

  logic half_bad;
  logic word_bad;

  // Byte accesses can never be misaligned; size 2 behaves as a word.
  assign half_bad = (n_bytes == HALF) & addr_low[0];
  assign word_bad = n_bytes[1] & (addr_low != 2'b00);

  assign instr_misaligned = check_en & ~data_instr_bar & (addr_low != 2'b00);
  assign load_misaligned  = check_en & data_instr_bar & (half_bad | word_bad);

endmodule

// File: rtl/aftab_daru.sv
// AFTAB data/address read unit: reads 1, 2 or 4 bytes little-endian into a word.
// Optional macro DARU_MISALIGN_BLOCK_EN refuses starts that raise a misalignment flag.
module aftab_daru
  import aftab_daru_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  startDARU,
  input  logic [1:0]            nBytes,
  input  logic [ADDR_WIDTH-1:0] addrIn,
  input  logic [7:0]            memData,
  input  logic                  memReady,
  input  logic                  dataInstrBar,
  input  logic                  checkMisalignedDARU,
  output logic                  instrMisalignedFlag,
  output logic                  loadMisalignedFlag,
  output logic                  completeDARU,
  output logic [31:0]           dataOut,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  readMem
);

  daru_state_e             state;
  daru_state_e             state_next;
  logic [ADDR_WIDTH-1:0]   base;
  logic [LANE_W-1:0]       counter;
  logic [LANE_W-1:0]       nb;
  logic [LANE_W-1:0]       nb_in;
  logic                    start_ok;
  logic                    last_byte;

  aftab_daru_misalign_chk u_misalign_chk (
    .addr_low         (addrIn[1:0]),
    .n_bytes          (nBytes),
    .data_instr_bar   (dataInstrBar),
    .check_en         (checkMisalignedDARU),
    .instr_misaligned (instrMisalignedFlag),
    .load_misaligned  (loadMisalignedFlag)
  );

`ifdef DARU_MISALIGN_BLOCK_EN
  assign start_ok = startDARU & ~(instrMisalignedFlag | loadMisalignedFlag);
`else
  assign start_ok = startDARU;
`endif

  assign nb_in     = (nBytes == 2'd2) ? WORD : nBytes;
  assign last_byte = (counter == nb);
  assign addrOut   = base + ADDR_WIDTH'(counter);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    readMem      = 1'b0;
    completeDARU = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_next = READ;
      end
      READ: begin
        readMem = 1'b1;
        if (memReady && last_byte) state_next = DONE;
      end
      DONE: begin
        completeDARU = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter parks on the final lane so addrOut keeps the last address read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base    <= '0;
      counter <= '0;
      nb      <= '0;
      dataOut <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            base    <= addrIn;
            nb      <= nb_in;
            counter <= '0;
            dataOut <= '0;
          end
        end
        READ: begin
          if (memReady) begin
            dataOut[{counter, 3'b000} +: 8] <= memData;
            if (!last_byte) counter <= counter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_daru.sv
// Directed self-checking bench for aftab_daru with hand-computed expectations.
module tb_aftab_daru;

  logic        clk;
  logic        rst;
  logic        startDARU;
  logic [1:0]  nBytes;
  logic [31:0] addrIn;
  logic [7:0]  memData;
  logic        memReady;
  logic        dataInstrBar;
  logic        checkMisalignedDARU;
  logic        instrMisalignedFlag;
  logic        loadMisalignedFlag;
  logic        completeDARU;
  logic [31:0] dataOut;
  logic [31:0] addrOut;
  logic        readMem;

  int n_compared;
  int n_mismatched;

  logic [31:0] obs_addr [4];
  int          obs_pulses;
  int          obs_cycles;
  logic        obs_readmem_ok;
  logic        obs_hold_ok;
  logic        obs_done_now;
  logic        obs_done_readmem;

  aftab_daru #(.ADDR_WIDTH(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .startDARU           (startDARU),
    .nBytes              (nBytes),
    .addrIn              (addrIn),
    .memData             (memData),
    .memReady            (memReady),
    .dataInstrBar        (dataInstrBar),
    .checkMisalignedDARU (checkMisalignedDARU),
    .instrMisalignedFlag (instrMisalignedFlag),
    .loadMisalignedFlag  (loadMisalignedFlag),
    .completeDARU        (completeDARU),
    .dataOut             (dataOut),
    .addrOut             (addrOut),
    .readMem             (readMem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from IDLE and records what the DUT did; inputs change 1ns after each edge.
  task automatic run_access(input logic [31:0] addr, input logic [1:0] nb,
                            input logic [31:0] bytes, input int wait_cyc);
    int          n;
    logic [31:0] held;
    n = (nb == 2'd0) ? 1 : (nb == 2'd1) ? 2 : 4;
    obs_pulses = 0;
    obs_cycles = 0;
    obs_readmem_ok = 1'b1;
    obs_hold_ok = 1'b1;
    held = '0;
    addrIn = addr;
    nBytes = nb;
    startDARU = 1'b1;
    step();
    obs_cycles++;
    startDARU = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int w = 0; w < wait_cyc; w++) begin
          memReady = 1'b0;
          if (w == 0) held = addrOut;
          else if (addrOut !== held) obs_hold_ok = 1'b0;
          if (readMem !== 1'b1) obs_readmem_ok = 1'b0;
          if (completeDARU === 1'b1) obs_pulses++;
          step();
          obs_cycles++;
        end
        if (wait_cyc > 0 && addrOut !== held) obs_hold_ok = 1'b0;
      end
      if (readMem !== 1'b1) obs_readmem_ok = 1'b0;
      if (completeDARU === 1'b1) obs_pulses++;
      obs_addr[i] = addrOut;
      memData = bytes[8*i +: 8];
      memReady = 1'b1;
      step();
      obs_cycles++;
      memReady = 1'b0;
    end
    obs_done_now = completeDARU;
    obs_done_readmem = readMem;
    for (int k = 0; k < 3; k++) begin
      if (completeDARU === 1'b1) obs_pulses++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_compared++;
    if ({dataOut, addrOut, readMem, completeDARU} !== 66'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got data=%h addr=%h rd=%b cmp=%b, want all 0",
               dataOut, addrOut, readMem, completeDARU);
    end
    step();
    rst = 1'b1;
    step();
    n_compared++;
    if (readMem !== 1'b0 || completeDARU !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_idle: got rd=%b cmp=%b, want 0/0", readMem, completeDARU);
    end
  endtask

  task automatic test_word_fetch();
    dataInstrBar = 1'b1;
    run_access(32'd100, 2'd3, 32'h01400093, 0);
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (obs_addr[i] !== 32'd100 + 32'(i)) begin
        n_mismatched++;
        $display("[TB] FAIL word_addr[%0d]: got %0d, want %0d", i, obs_addr[i], 100 + i);
      end
    end
    n_compared++;
    if (dataOut !== 32'h01400093) begin
      n_mismatched++;
      $display("[TB] FAIL word_data: got %h, want 01400093", dataOut);
    end
    n_compared++;
    if (obs_pulses !== 1 || obs_done_now !== 1'b1 || obs_done_readmem !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL word_complete: got pulses=%0d done=%b rd=%b, want 1/1/0",
               obs_pulses, obs_done_now, obs_done_readmem);
    end
    n_compared++;
    if (obs_readmem_ok !== 1'b1 || obs_cycles !== 5) begin
      n_mismatched++;
      $display("[TB] FAIL word_timing: got rd_ok=%b cycles=%0d, want 1/5", obs_readmem_ok, obs_cycles);
    end
    n_compared++;
    if (dataOut !== 32'h01400093 || addrOut !== 32'd103) begin
      n_mismatched++;
      $display("[TB] FAIL word_hold: got data=%h addr=%0d, want 01400093/103", dataOut, addrOut);
    end
  endtask

  task automatic test_byte_half();
    run_access(32'd200, 2'd0, 32'h000000FF, 0);
    n_compared++;
    if (dataOut !== 32'h000000FF || obs_addr[0] !== 32'd200 || obs_pulses !== 1 || obs_cycles !== 2) begin
      n_mismatched++;
      $display("[TB] FAIL byte_read: got data=%h addr=%0d pulses=%0d cycles=%0d, want 000000ff/200/1/2",
               dataOut, obs_addr[0], obs_pulses, obs_cycles);
    end
    run_access(32'd202, 2'd1, 32'h00001234, 0);
    n_compared++;
    if (dataOut !== 32'h00001234 || obs_addr[1] !== 32'd203 || obs_pulses !== 1 || obs_cycles !== 3) begin
      n_mismatched++;
      $display("[TB] FAIL half_read: got data=%h addr1=%0d pulses=%0d cycles=%0d, want 00001234/203/1/3",
               dataOut, obs_addr[1], obs_pulses, obs_cycles);
    end
    run_access(32'd40, 2'd2, 32'hA1B2C3D4, 0);
    n_compared++;
    if (dataOut !== 32'hA1B2C3D4 || obs_addr[3] !== 32'd43 || obs_cycles !== 5) begin
      n_mismatched++;
      $display("[TB] FAIL size2_as_word: got data=%h addr3=%0d cycles=%0d, want a1b2c3d4/43/5",
               dataOut, obs_addr[3], obs_cycles);
    end
  endtask

  task automatic test_wait_states();
    run_access(32'd300, 2'd3, 32'hDEADBEEF, 3);
    n_compared++;
    if (dataOut !== 32'hDEADBEEF || obs_hold_ok !== 1'b1 || obs_readmem_ok !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wait_data: got data=%h hold=%b rd_ok=%b, want deadbeef/1/1",
               dataOut, obs_hold_ok, obs_readmem_ok);
    end
    n_compared++;
    if (obs_cycles !== 14 || obs_pulses !== 1 || obs_addr[3] !== 32'd303) begin
      n_mismatched++;
      $display("[TB] FAIL wait_timing: got cycles=%0d pulses=%0d addr3=%0d, want 14/1/303",
               obs_cycles, obs_pulses, obs_addr[3]);
    end
  endtask

  task automatic test_idle_memready();
    memData = 8'hAA;
    memReady = 1'b1;
    step();
    step();
    memReady = 1'b0;
    n_compared++;
    if (dataOut !== 32'hDEADBEEF || readMem !== 1'b0 || completeDARU !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_memready: got data=%h rd=%b cmp=%b, want deadbeef/0/0",
               dataOut, readMem, completeDARU);
    end
  endtask

  task automatic test_misalign();
    logic [1:0] exp_flags [6];
    logic [1:0] got;
    logic       exp_rd;
    logic [31:0] v_addr [6];
    logic [1:0]  v_nb [6];
    logic        v_dib [6];
    logic        v_chk [6];
    v_addr = '{32'd101, 32'd101, 32'd100, 32'd102, 32'd100, 32'd103};
    v_nb   = '{2'd1, 2'd0, 2'd1, 2'd3, 2'd3, 2'd3};
    v_dib  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    v_chk  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_flags = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      addrIn = v_addr[i];
      nBytes = v_nb[i];
      dataInstrBar = v_dib[i];
      checkMisalignedDARU = v_chk[i];
      #1;
      got = {instrMisalignedFlag, loadMisalignedFlag};
      n_compared++;
      if (got !== exp_flags[i]) begin
        n_mismatched++;
        $display("[TB] FAIL misalign_vec%0d: got {instr,load}=%b, want %b", i, got, exp_flags[i]);
      end
    end
    step();
`ifdef DARU_MISALIGN_BLOCK_EN
    exp_rd = 1'b0;
`else
    exp_rd = 1'b1;
`endif
    addrIn = 32'd101;
    nBytes = 2'd1;
    dataInstrBar = 1'b1;
    checkMisalignedDARU = 1'b1;
    startDARU = 1'b1;
    step();
    startDARU = 1'b0;
    n_compared++;
    if (readMem !== exp_rd || completeDARU !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL misalign_start: got rd=%b cmp=%b, want %b/0", readMem, completeDARU, exp_rd);
    end
    memData = 8'h00;
    memReady = 1'b1;
    for (int k = 0; k < 4; k++) step();
    memReady = 1'b0;
    checkMisalignedDARU = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_access();
    int pulses;
    pulses = 0;
    addrIn = 32'd500;
    nBytes = 2'd3;
    startDARU = 1'b1;
    step();
    startDARU = 1'b0;
    memReady = 1'b1;
    memData = 8'h11;
    step();
    memData = 8'h22;
    step();
    memReady = 1'b0;
    rst = 1'b0;
    #2;
    n_compared++;
    if ({dataOut, addrOut, readMem, completeDARU} !== 66'd0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_outputs: got data=%h addr=%h rd=%b cmp=%b, want all 0",
               dataOut, addrOut, readMem, completeDARU);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (completeDARU === 1'b1 || readMem === 1'b1) pulses++;
    end
    n_compared++;
    if (pulses !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_idle: got %0d active cycles, want 0", pulses);
    end
    run_access(32'd600, 2'd3, 32'h89ABCDEF, 0);
    n_compared++;
    if (dataOut !== 32'h89ABCDEF || obs_pulses !== 1 || obs_addr[0] !== 32'd600) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_recover: got data=%h pulses=%0d addr0=%0d, want 89abcdef/1/600",
               dataOut, obs_pulses, obs_addr[0]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    run_access(32'hFFFFFFFE, 2'd3, 32'h04030201, 0);
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (obs_addr[i] !== exp_a[i]) begin
        n_mismatched++;
        $display("[TB] FAIL wrap_addr[%0d]: got %h, want %h", i, obs_addr[i], exp_a[i]);
      end
    end
    n_compared++;
    if (dataOut !== 32'h04030201) begin
      n_mismatched++;
      $display("[TB] FAIL wrap_data: got %h, want 04030201", dataOut);
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    startDARU = 1'b0;
    nBytes = 2'd0;
    addrIn = '0;
    memData = '0;
    memReady = 1'b0;
    dataInstrBar = 1'b1;
    checkMisalignedDARU = 1'b0;
    test_reset();
    test_word_fetch();
    test_byte_half();
    test_wait_states();
    test_idle_memready();
    test_misalign();
    test_reset_mid_access();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
